// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the requester channels and mem_arbiter.
// Channel c owns addr[c*ADDR_W +: ADDR_W] and wdata[c*DATA_W +: DATA_W].
interface mem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        we;
    logic [NUM_CH*ADDR_W-1:0] addr;
    logic [NUM_CH*DATA_W-1:0] wdata;
    logic [NUM_CH-1:0]        gnt;
    logic [NUM_CH-1:0]        rvalid;
    logic [DATA_W-1:0]        rdata;
    logic [NUM_CH-1:0]        err;
    logic                     busy;

    // Requester side
    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err, busy
    );

    // Arbiter side
    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Multi-channel arbiter in front of a single-port DEPTH x DATA_W memory.
// One access per cycle; grant, read data and error all appear one cycle
// after the selecting edge. A channel that was granted last cycle is not
// eligible this cycle, so a held req is never served twice for one request.
module mem_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 1024,
    parameter int NUM_CH   = 2,
    parameter int ARB_MODE = 0
) (
    input  logic         clock,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [NUM_CH-1:0] rvalid_q, rvalid_d;
    logic [NUM_CH-1:0] err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;

    logic [NUM_CH-1:0] elig;
    logic              sel_vld;
    logic [CH_W-1:0]   sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;
    logic [MEM_AW-1:0] mem_idx;
    logic              access;
    logic              mem_wr;

    // Channel selection: loops run from lowest to highest priority so the
    // last hit (the highest-priority eligible channel) wins.
    always_comb begin
        elig    = bus.req & ~gnt_q;
        sel_vld = 1'b0;
        sel     = '0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    sel_vld = 1'b1;
                    sel     = CH_W'(i);
                end
            end
        end else begin
            for (int off = NUM_CH; off >= 1; off--) begin
                if (elig[(int'(ptr_q) + off) % NUM_CH]) begin
                    sel_vld = 1'b1;
                    sel     = CH_W'((int'(ptr_q) + off) % NUM_CH);
                end
            end
        end
    end

    // Sample the winner's command; reset_n gating drops any access at an
    // edge where reset is already asserted, including the memory write.
    always_comb begin
        sel_we    = bus.we[sel];
        sel_addr  = bus.addr[int'(sel) * ADDR_W +: ADDR_W];
        sel_wdata = bus.wdata[int'(sel) * DATA_W +: DATA_W];
        in_range  = ({1'b0, sel_addr} < DEPTH_LIM);
        mem_idx   = sel_addr[MEM_AW-1:0];
        access    = sel_vld & reset_n;
        mem_wr    = access & sel_we & in_range;
    end

    // Next-state for the response registers and round-robin pointer
    always_comb begin
        gnt_d    = '0;
        rvalid_d = '0;
        err_d    = '0;
        rdata_d  = rdata_q;
        ptr_d    = ptr_q;
        if (access) begin
            gnt_d[sel] = 1'b1;
            ptr_d      = sel;
            if (!in_range) begin
                err_d[sel] = 1'b1;
                if (!sel_we) begin
                    rvalid_d[sel] = 1'b1;
                    rdata_d       = '0;
                end
            end else if (!sel_we) begin
                rvalid_d[sel] = 1'b1;
                rdata_d       = mem[mem_idx];
            end
        end
    end

    // Response and pointer registers; ptr resets so channel 0 is searched first
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            ptr_q    <= CH_W'(NUM_CH - 1);
        end else begin
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            ptr_q    <= ptr_d;
        end
    end

    // Memory array has no reset so its contents survive reset
    always_ff @(posedge clock) begin
        if (mem_wr) begin
            mem[mem_idx] <= sel_wdata;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign bus.rdata  = rdata_q;
    assign bus.busy   = |gnt_q;
endmodule
